// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: size encodings, dump FSM
// states and the lane-enable / alignment helpers.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } dump_state_t;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: lane_mask = 4'b0001 << lane;
         SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = lane[0];
         SZ_WORD: is_misaligned = |lane;
         default: is_misaligned = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_bytelane_if.sv
// CPU load/store bus plus streaming dump port of the byte-lane data memory.
// DMEM_PARITY_EN adds parity_err and dump_par.
interface data_memory_bytelane_if #(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH) + 2
);
   logic [ADDR_W-1:0]        addr;
   logic [31:0]              write_data;
   logic                     MemRead;
   logic                     MemWrite;
   logic [1:0]               size;
   logic                     ld_unsigned;
   logic [31:0]              read_data;
   logic                     misaligned;
   logic                     dump_start;
   logic                     dump_ready;
   logic                     dump_valid;
   logic [$clog2(DEPTH)-1:0] dump_addr;
   logic [31:0]              dump_data;
   logic                     dump_busy;
   logic                     dump_done;
`ifdef DMEM_PARITY_EN
   logic                     parity_err;
   logic [3:0]               dump_par;
`endif

   modport master (
      output addr, write_data, MemRead, MemWrite, size, ld_unsigned, dump_start, dump_ready,
      input  read_data, misaligned, dump_valid, dump_addr, dump_data, dump_busy, dump_done
`ifdef DMEM_PARITY_EN
      , input parity_err, dump_par
`endif
   );

   modport slave (
      input  addr, write_data, MemRead, MemWrite, size, ld_unsigned, dump_start, dump_ready,
      output read_data, misaligned, dump_valid, dump_addr, dump_data, dump_busy, dump_done
`ifdef DMEM_PARITY_EN
      , output parity_err, dump_par
`endif
   );

endinterface

// File: rtl/dmem_dump_ctrl.sv
// Dump streaming FSM: walks word indices 0..DEPTH-1 over a valid/ready port,
// capturing each word from the parent one edge before it is presented.
//
// state | meaning
// IDLE  | waiting for start; requests word 0 for capture
// SEND  | beat valid; on accept capture next word or finish
// DONE  | one-cycle done pulse, then back to IDLE
module dmem_dump_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int DW    = 32,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ready,
   input  logic [DW-1:0] rd_word,
   output logic [IW-1:0] rd_idx,
   output logic          valid,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] idx,
   output logic [DW-1:0] data
);

   dump_state_t state;

   // Word index the parent must present on rd_word for the next capture.
   assign rd_idx = (state == SEND) ? idx + IW'(1) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         idx   <= '0;
         data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  idx   <= '0;
                  data  <= rd_word;
                  valid <= 1'b1;
                  busy  <= 1'b1;
                  state <= SEND;
               end
            end
            SEND: begin
               if (valid && ready) begin
                  if (idx == IW'(DEPTH - 1)) begin
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx  <= idx + IW'(1);
                     data <= rd_word;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/data_memory_bytelane.sv
// Byte-addressed little-endian data memory with sub-word loads/stores and a
// streaming dump port. Define DMEM_PARITY_EN for per-lane even parity.
module data_memory_bytelane
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 128,
   parameter int ADDR_W = $clog2(DEPTH) + 2
) (
   input logic                   clk,
   input logic                   reset,
   data_memory_bytelane_if.slave bus
);

   localparam int IW = $clog2(DEPTH);
`ifdef DMEM_PARITY_EN
   localparam int DW = 36;
`else
   localparam int DW = 32;
`endif

   logic [31:0]   mem [DEPTH];
   logic [IW-1:0] widx;
   logic [1:0]    lane;
   logic [31:0]   word;
   logic [31:0]   wlanes;
   logic [3:0]    wmask;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   rdata;

   assign widx = bus.addr[ADDR_W-1:2];
   assign lane = bus.addr[1:0];
   assign word = mem[widx];

   assign bus.misaligned = (bus.MemRead || bus.MemWrite) && is_misaligned(bus.size, lane);
   assign wmask = (bus.MemWrite && !bus.misaligned) ? lane_mask(bus.size, lane) : 4'b0000;

   // Replicate store data across lanes so the mask alone selects placement.
   always_comb begin
      case (bus.size)
         SZ_BYTE: wlanes = {4{bus.write_data[7:0]}};
         SZ_HALF: wlanes = {2{bus.write_data[15:0]}};
         default: wlanes = bus.write_data;
      endcase
   end

   always_comb begin
      case (lane)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      sel_half = lane[1] ? word[31:16] : word[15:0];
      rdata    = '0;
      if (bus.MemRead && !bus.misaligned) begin
         case (bus.size)
            SZ_BYTE: rdata = {{24{sel_byte[7] & ~bus.ld_unsigned}}, sel_byte};
            SZ_HALF: rdata = {{16{sel_half[15] & ~bus.ld_unsigned}}, sel_half};
            SZ_WORD: rdata = word;
            default: rdata = '0;
         endcase
      end
   end
   assign bus.read_data = rdata;

`ifdef DMEM_PARITY_EN
   logic [3:0] par [DEPTH];
   logic [3:0] word_par;
   assign word_par = {^word[31:24], ^word[23:16], ^word[15:8], ^word[7:0]};
   assign bus.parity_err = bus.MemRead && !bus.misaligned &&
                           |((word_par ^ par[widx]) & lane_mask(bus.size, lane));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
`ifdef DMEM_PARITY_EN
            par[i] <= '0;
`endif
         end
      end else begin
         for (int l = 0; l < 4; l++) begin
            if (wmask[l]) begin
               mem[widx][8*l +: 8] <= wlanes[8*l +: 8];
`ifdef DMEM_PARITY_EN
               par[widx][l] <= ^wlanes[8*l +: 8];
`endif
            end
         end
      end
   end

   logic [IW-1:0] cap_idx;
   logic [DW-1:0] cap_word;
   logic [DW-1:0] dump_word;

`ifdef DMEM_PARITY_EN
   assign cap_word     = {par[cap_idx], mem[cap_idx]};
   assign bus.dump_par = dump_word[35:32];
   assign bus.dump_data = dump_word[31:0];
`else
   assign cap_word      = mem[cap_idx];
   assign bus.dump_data = dump_word;
`endif

   dmem_dump_ctrl #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .IW    (IW)
   ) u_dump (
      .clk     (clk),
      .reset   (reset),
      .start   (bus.dump_start),
      .ready   (bus.dump_ready),
      .rd_word (cap_word),
      .rd_idx  (cap_idx),
      .valid   (bus.dump_valid),
      .busy    (bus.dump_busy),
      .done    (bus.dump_done),
      .idx     (bus.dump_addr),
      .data    (dump_word)
   );

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Self-checking bench for data_memory_bytelane: directed vector table, random
// loads/stores against an arithmetic reference model, and dump sequences.
module tb_data_memory_bytelane;

   localparam int DEPTH = 128;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   data_memory_bytelane_if #(.DEPTH(DEPTH)) bus ();

   data_memory_bytelane #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] snap  [DEPTH];

   typedef struct {
      bit          rd;
      bit          wr;
      logic [8:0]  addr;
      logic [1:0]  size;
      bit          uns;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_mis;
   } vec_t;
   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [8:0] a, input logic [1:0] sz,
                        input bit u, input logic [31:0] d);
      bus.MemRead     = rd;
      bus.MemWrite    = wr;
      bus.addr        = a;
      bus.size        = sz;
      bus.ld_unsigned = u;
      bus.write_data  = d;
   endtask

   task automatic idle_bus();
      drive(1'b0, 1'b0, 9'd0, 2'b10, 1'b0, 32'd0);
   endtask

   function automatic bit exp_mis(input int a, input int sz, input bit rd, input bit wr);
      return (rd || wr) && (sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
   endfunction

   function automatic logic [31:0] exp_load(input int a, input int sz, input bit u);
      longint v;
      longint w;
      w = longint'(model[a / 4]);
      if (sz == 0) begin
         v = (w >> (8 * (a % 4))) % 256;
         if (!u && v >= 128) v = v - 256;
      end else if (sz == 1) begin
         v = (w >> (16 * ((a % 4) / 2))) % 65536;
         if (!u && v >= 32768) v = v - 65536;
      end else begin
         v = w;
      end
      return 32'(v);
   endfunction

   function automatic void model_store(input int a, input int sz, input logic [31:0] d);
      int sh;
      logic [31:0] m;
      if (sz == 0) begin
         sh = 8 * (a % 4);
         m  = 32'h0000_00FF << sh;
      end else if (sz == 1) begin
         sh = 16 * ((a % 4) / 2);
         m  = 32'h0000_FFFF << sh;
      end else begin
         sh = 0;
         m  = 32'hFFFF_FFFF;
      end
      model[a / 4] = (model[a / 4] & ~m) | ((d << sh) & m);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      idle_bus();
      bus.dump_start = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int a, sz, cyc, nb;
      bit rd, wr, u, em, swdone, seen_done;
      logic [31:0] d, er, newv;

      vecs[0]  = '{1'b0, 1'b1, 9'h010, 2'b10, 1'b0, 32'h8000_00FF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 9'h010, 2'b00, 1'b0, 32'h0,         32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 9'h010, 2'b00, 1'b1, 32'h0,         32'h0000_00FF, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 9'h013, 2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 9'h020, 2'b10, 1'b0, 32'h1111_1111, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 9'h022, 2'b01, 1'b0, 32'h0000_BEEF, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 9'h020, 2'b10, 1'b0, 32'h0,         32'hBEEF_1111, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 9'h022, 2'b01, 1'b1, 32'h0,         32'h0000_BEEF, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 9'h022, 2'b01, 1'b0, 32'h0,         32'hFFFF_BEEF, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 9'h005, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 9'h004, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 9'h003, 2'b01, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 9'h000, 2'b11, 1'b0, 32'h0,         32'h0000_0000, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 9'h021, 2'b00, 1'b0, 32'h1234_56A5, 32'h0000_0000, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 9'h020, 2'b10, 1'b0, 32'h0,         32'hBEEF_A511, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 9'h020, 2'b01, 1'b0, 32'h0,         32'hFFFF_A511, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 9'h020, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 9'h012, 2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b1};

      bus.dump_start = 1'b0;
      bus.dump_ready = 1'b0;
      do_reset();

      // Reset state
      drive(1'b1, 1'b0, 9'h010, 2'b10, 1'b0, 32'd0);
      #1;
      chk("reset_mem", bus.read_data, 32'd0);
      chk("reset_valid", {31'd0, bus.dump_valid}, 32'd0);
      chk("reset_busy", {31'd0, bus.dump_busy}, 32'd0);
      chk("reset_done", {31'd0, bus.dump_done}, 32'd0);
      chk("reset_daddr", {25'd0, bus.dump_addr}, 32'd0);
      chk("reset_ddata", bus.dump_data, 32'd0);
      step();

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wd);
         #1;
         chk($sformatf("vec%0d_rd", i), bus.read_data, vecs[i].exp_rd);
         chk($sformatf("vec%0d_mis", i), {31'd0, bus.misaligned}, {31'd0, vecs[i].exp_mis});
         if (vecs[i].wr && !vecs[i].exp_mis)
            model_store(int'(vecs[i].addr), int'(vecs[i].size), vecs[i].wd);
         step();
      end

      // Randomized loads/stores against the reference model
      for (int i = 0; i < 400; i++) begin
         a  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 63) : $urandom_range(0, 4 * DEPTH - 1);
         sz = $urandom_range(0, 3);
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         d  = $urandom;
         drive(rd, wr, 9'(a), 2'(sz), u, d);
         #1;
         em = exp_mis(a, sz, rd, wr);
         er = (rd && !em) ? exp_load(a, sz, u) : 32'd0;
         chk("rand_mis", {31'd0, bus.misaligned}, {31'd0, em});
         chk("rand_rd", bus.read_data, er);
         if (wr && !em) model_store(a, sz, d);
         step();
      end
      idle_bus();

      // Full-speed dump
      bus.dump_ready = 1'b1;
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         chk("dumpA_valid", {31'd0, bus.dump_valid}, 32'd1);
         chk("dumpA_busy", {31'd0, bus.dump_busy}, 32'd1);
         chk("dumpA_addr", {25'd0, bus.dump_addr}, 32'(k));
         chk("dumpA_data", bus.dump_data, model[k]);
         step();
      end
      chk("dumpA_done", {31'd0, bus.dump_done}, 32'd1);
      chk("dumpA_end_valid", {31'd0, bus.dump_valid}, 32'd0);
      chk("dumpA_end_busy", {31'd0, bus.dump_busy}, 32'd0);
      step();
      chk("dumpA_done_clear", {31'd0, bus.dump_done}, 32'd0);
      step();

      // Dump with random backpressure and a store at the capture of word 3
      for (int i = 0; i < DEPTH; i++) snap[i] = model[i];
      newv = 32'hC0FF_EE03 ^ snap[3] ^ 32'h5A5A_0000;
      if (newv == snap[3]) newv = ~newv;
      nb = 0;
      cyc = 0;
      swdone = 1'b0;
      bus.dump_ready = 1'b0;
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      while (nb < DEPTH && cyc < 3000) begin
         chk("dumpB_valid", {31'd0, bus.dump_valid}, 32'd1);
         chk("dumpB_addr", {25'd0, bus.dump_addr}, 32'(nb));
         chk("dumpB_data", bus.dump_data, snap[nb]);
         bus.dump_ready = 1'($urandom_range(0, 1));
         if (nb == 2 && bus.dump_ready && !swdone) begin
            drive(1'b0, 1'b1, 9'h00C, 2'b10, 1'b0, newv);
            model_store(12, 2, newv);
            swdone = 1'b1;
         end else begin
            idle_bus();
         end
         if (bus.dump_ready) nb++;
         step();
         cyc++;
      end
      idle_bus();
      chk("dumpB_beats", 32'(nb), 32'(DEPTH));
      chk("dumpB_done", {31'd0, bus.dump_done}, 32'd1);
      drive(1'b1, 1'b0, 9'h00C, 2'b10, 1'b0, 32'd0);
      #1;
      chk("dumpB_new_word3", bus.read_data, newv);
      step();
      idle_bus();

      // Reset in the middle of a dump
      bus.dump_ready = 1'b1;
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      cyc = 0;
      while (bus.dump_addr != 7'd40 && cyc < 300) begin
         step();
         cyc++;
      end
      chk("dumpC_reach40", {25'd0, bus.dump_addr}, 32'd40);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      chk("dumpC_valid", {31'd0, bus.dump_valid}, 32'd0);
      chk("dumpC_busy", {31'd0, bus.dump_busy}, 32'd0);
      chk("dumpC_done", {31'd0, bus.dump_done}, 32'd0);
      chk("dumpC_daddr", {25'd0, bus.dump_addr}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("dumpC_no_done", {31'd0, bus.dump_done}, 32'd0);
      end
      for (int w = 0; w < DEPTH; w++) begin
         drive(1'b1, 1'b0, 9'(4 * w), 2'b10, 1'b0, 32'd0);
         #1;
         chk("dumpC_cleared", bus.read_data, 32'd0);
         step();
      end
      idle_bus();
      bus.dump_start = 1'b1;
      step();
      bus.dump_start = 1'b0;
      chk("dumpC_restart_valid", {31'd0, bus.dump_valid}, 32'd1);
      chk("dumpC_restart_busy", {31'd0, bus.dump_busy}, 32'd1);
      chk("dumpC_restart_addr", {25'd0, bus.dump_addr}, 32'd0);
      seen_done = 1'b0;
      cyc = 0;
      while (!seen_done && cyc < 300) begin
         if (bus.dump_done) seen_done = 1'b1;
         else begin
            step();
            cyc++;
         end
      end
      chk("dumpC_restart_done", {31'd0, seen_done}, 32'd1);
      chk("dumpC_restart_cycles", 32'(cyc), 32'(DEPTH));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
